// File: rtl/tft_frame_monitor_if.sv
// Panel-side TFT pixel stream bundle: the driver owns it (master), the
// frame monitor observes it (slave).
interface tft_frame_monitor_if;
    logic       tft_data_ena;
    logic [7:0] tft_red;
    logic [7:0] tft_green;
    logic [7:0] tft_blue;
    logic       new_frame;

    modport master (output tft_data_ena, tft_red, tft_green, tft_blue, new_frame);
    modport slave  (input  tft_data_ena, tft_red, tft_green, tft_blue, new_frame);
endinterface

// File: rtl/tft_frame_monitor.sv
// Receive-side TFT stream checker: line/frame geometry, colour match count, probed pixel.
// Optional blanking-data check is enabled by defining TFT_MON_BLANK_CHECK_EN.
module tft_frame_monitor #(
    parameter int X_RES          = 480,
    parameter int Y_RES          = 272,
    parameter int BITS_PER_COLOR = 3,
    parameter int CNT_W          = 10
) (
    input  logic                          tft_clk,
    input  logic                          rstb,
    tft_frame_monitor_if.slave            tft,
    input  logic [3*BITS_PER_COLOR-1:0]   match_rgb,
    input  logic [CNT_W-1:0]              probe_x,
    input  logic [CNT_W-1:0]              probe_y,
    output logic                          frame_done,
    output logic [CNT_W-1:0]              line_len,
    output logic [CNT_W-1:0]              frame_lines,
    output logic                          geom_err,
    output logic [17:0]                   match_count,
    output logic [3*BITS_PER_COLOR-1:0]   probe_pixel,
    output logic                          probe_hit,
    output logic                          blank_err
);
    localparam int               PW        = 3*BITS_PER_COLOR;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [17:0]      MATCH_MAX = '1;
    localparam logic [CNT_W-1:0] X_TGT     = CNT_W'(X_RES);
    localparam logic [CNT_W-1:0] Y_TGT     = CNT_W'(Y_RES);

    typedef enum logic [1:0] {WAIT_SYNC, BLANK, LINE} state_t;
    state_t state;

    logic             ena, ena_d, nf_d, ena_rise, nf_rise;
    logic [CNT_W-1:0] x_cnt, y_cnt, w_line_len;
    logic             w_geom_err, w_hit;
    logic [17:0]      w_match;
    logic [PW-1:0]    w_pix, rgb;

    logic             in_line, frame_close, close_line, pix_valid, pix_match, pix_probe, geom_next;
    logic [CNT_W-1:0] y_next, len_next, pix_x, pix_y;

    assign ena      = tft.tft_data_ena;
    assign ena_rise = ena & ~ena_d;
    assign nf_rise  = tft.new_frame & ~nf_d;
    assign rgb      = {tft.tft_red[7 -: BITS_PER_COLOR], tft.tft_green[7 -: BITS_PER_COLOR],
                       tft.tft_blue[7 -: BITS_PER_COLOR]};

    // A frame close with ena high makes that cycle pixel (0,0) of the new frame.
    always_comb begin
        in_line     = (state == LINE);
        frame_close = nf_rise && (state != WAIT_SYNC);
        close_line  = in_line && (!ena || nf_rise);
        y_next      = (close_line && y_cnt != CNT_MAX) ? y_cnt + 1'b1 : y_cnt;
        len_next    = close_line ? x_cnt : w_line_len;
        geom_next   = w_geom_err || (close_line && x_cnt != X_TGT);
        pix_valid   = ena && (frame_close || in_line || (state == BLANK && ena_rise));
        pix_x       = (in_line && !frame_close) ? x_cnt : '0;
        pix_y       = frame_close ? '0 : y_cnt;
        pix_match   = pix_valid && (rgb == match_rgb);
        pix_probe   = pix_valid && (pix_x == probe_x) && (pix_y == probe_y);
    end

    always_ff @(posedge tft_clk) begin
        if (!rstb) begin
            state       <= WAIT_SYNC;
            ena_d       <= 1'b0;
            nf_d        <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            w_line_len  <= '0;
            w_geom_err  <= 1'b0;
            w_match     <= '0;
            w_pix       <= '0;
            w_hit       <= 1'b0;
            frame_done  <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            geom_err    <= 1'b0;
            match_count <= '0;
            probe_pixel <= '0;
            probe_hit   <= 1'b0;
        end else begin
            ena_d      <= ena;
            nf_d       <= tft.new_frame;
            frame_done <= 1'b0;
            if (state == WAIT_SYNC) begin
                if (nf_rise) begin
                    state      <= BLANK;
                    x_cnt      <= '0;
                    y_cnt      <= '0;
                    w_line_len <= '0;
                    w_geom_err <= 1'b0;
                    w_match    <= '0;
                    w_pix      <= '0;
                    w_hit      <= 1'b0;
                end
            end else if (frame_close) begin
                frame_done  <= 1'b1;
                line_len    <= len_next;
                frame_lines <= y_next;
                geom_err    <= geom_next || (y_next != Y_TGT);
                match_count <= w_match;
                probe_pixel <= w_pix;
                probe_hit   <= w_hit;
                y_cnt       <= '0;
                w_line_len  <= '0;
                w_geom_err  <= 1'b0;
                w_match     <= {17'd0, pix_match};
                w_hit       <= pix_probe;
                w_pix       <= pix_probe ? rgb : '0;
                state       <= ena ? LINE : BLANK;
                x_cnt       <= ena ? CNT_W'(1) : '0;
            end else begin
                if (in_line && !ena) begin
                    state      <= BLANK;
                    y_cnt      <= y_next;
                    w_line_len <= len_next;
                    w_geom_err <= geom_next;
                end else if (in_line) begin
                    if (x_cnt != CNT_MAX) x_cnt <= x_cnt + 1'b1;
                end else if (ena_rise) begin
                    state <= LINE;
                    x_cnt <= CNT_W'(1);
                end
                if (pix_match && w_match != MATCH_MAX) w_match <= w_match + 1'b1;
                if (pix_probe) begin
                    w_pix <= rgb;
                    w_hit <= 1'b1;
                end
            end
        end
    end

`ifdef TFT_MON_BLANK_CHECK_EN
    localparam logic [7:0] LO_MASK = 8'((1 << (8 - BITS_PER_COLOR)) - 1);
    logic [7:0] any_bits;
    assign any_bits = tft.tft_red | tft.tft_green | tft.tft_blue;

    always_ff @(posedge tft_clk) begin
        if (!rstb)
            blank_err <= 1'b0;
        else if ((!ena && state != WAIT_SYNC && |any_bits) || (ena && |(any_bits & LO_MASK)))
            blank_err <= 1'b1;
    end
`else
    assign blank_err = 1'b0;
`endif
endmodule

// File: tb/tb_tft_frame_monitor.sv
// Directed bench for tft_frame_monitor on a scaled 32x20 raster (5-cycle line gaps).
module tb_tft_frame_monitor;
    localparam int XR = 32;
    localparam int YR = 20;

    logic        tft_clk = 1'b0;
    logic        rstb    = 1'b0;
    logic [8:0]  match_rgb;
    logic [9:0]  probe_x, probe_y;
    logic        frame_done, geom_err, probe_hit, blank_err;
    logic [9:0]  line_len, frame_lines;
    logic [17:0] match_count;
    logic [8:0]  probe_pixel;

    int n_tests  = 0;
    int n_fail   = 0;
    int fd_count = 0;
    int fd_base;
    bit sq_en    = 1'b0;

    tft_frame_monitor_if tft();

    tft_frame_monitor #(.X_RES(XR), .Y_RES(YR), .BITS_PER_COLOR(3), .CNT_W(10)) dut (
        .tft_clk(tft_clk), .rstb(rstb), .tft(tft),
        .match_rgb(match_rgb), .probe_x(probe_x), .probe_y(probe_y),
        .frame_done(frame_done), .line_len(line_len), .frame_lines(frame_lines),
        .geom_err(geom_err), .match_count(match_count), .probe_pixel(probe_pixel),
        .probe_hit(probe_hit), .blank_err(blank_err)
    );

    always #5 tft_clk = ~tft_clk;

    always @(negedge tft_clk) if (frame_done === 1'b1) fd_count++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge tft_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus;
        tft.tft_data_ena = 1'b0;
        tft.tft_red      = 8'h00;
        tft.tft_green    = 8'h00;
        tft.tft_blue     = 8'h00;
    endtask

    // Orange {7,5,0} background, optional blue {0,0,7} 7x7 square at x,y in [4..10]x[3..9].
    task automatic set_pix(input int x, input int y);
        if (sq_en && x >= 4 && x <= 10 && y >= 3 && y <= 9) begin
            tft.tft_red = 8'h00; tft.tft_green = 8'h00; tft.tft_blue = 8'hE0;
        end else begin
            tft.tft_red = 8'hE0; tft.tft_green = 8'hA0; tft.tft_blue = 8'h00;
        end
    endtask

    task automatic send_line(input int len, input int y, input bit nf_first);
        for (int x = 0; x < len; x++) begin
            tft.tft_data_ena = 1'b1;
            set_pix(x, y);
            if (nf_first && x == 0) tft.new_frame = 1'b1;
            else                    tft.new_frame = 1'b0;
            tick();
            if (nf_first && x == 0) check("coincident frame_done", 32'(frame_done), 1);
        end
        tft.new_frame = 1'b0;
        idle_bus();
        repeat (5) tick();
    endtask

    task automatic send_frame(input int nlines, input int short_y);
        for (int y = 0; y < nlines; y++) send_line((y == short_y) ? XR - 1 : XR, y, 1'b0);
    endtask

    task automatic pulse_nf(input string tag, input bit exp);
        tft.new_frame = 1'b1;
        tick();
        check({tag, " frame_done"}, 32'(frame_done), 32'(exp));
        tft.new_frame = 1'b0;
        tick();
        check({tag, " frame_done drop"}, 32'(frame_done), 0);
        repeat (3) tick();
    endtask

    task automatic check_results(input string tag, input int len, input int lines, input int geom,
                                 input int mc, input int pp, input int ph);
        check({tag, " line_len"},    32'(line_len),    len);
        check({tag, " frame_lines"}, 32'(frame_lines), lines);
        check({tag, " geom_err"},    32'(geom_err),    geom);
        check({tag, " match_count"}, 32'(match_count), mc);
        check({tag, " probe_pixel"}, 32'(probe_pixel), pp);
        check({tag, " probe_hit"},   32'(probe_hit),   ph);
    endtask

    initial begin
        idle_bus();
        tft.new_frame = 1'b0;
        match_rgb = 9'o007;
        probe_x   = 10'd16;
        probe_y   = 10'd10;
        repeat (3) tick();
        check("reset frame_done", 32'(frame_done), 0);
        check_results("reset", 0, 0, 0, 0, 0, 0);
        check("reset blank_err", 32'(blank_err), 0);
        rstb = 1'b1;
        tick();

        // First edge only syncs; frame A: clean, blue square, probe on orange.
        pulse_nf("sync", 1'b0);
        sq_en = 1'b1;
        send_frame(YR, -1);
        pulse_nf("frame A", 1'b1);
        check_results("frame A", XR, YR, 0, 49, 9'o750, 1);
        check("frame A blank_err", 32'(blank_err), 0);

        // Frame B: line 10 one pixel short, count orange, probe off-raster.
        sq_en = 1'b0; match_rgb = 9'o750; probe_x = 10'd500; probe_y = 10'd0;
        send_frame(YR, 10);
        pulse_nf("frame B", 1'b1);
        check_results("frame B", XR, YR, 1, XR*YR - 1, 0, 0);

        // Frame C: clean again, probe at left edge of last line.
        match_rgb = 9'o007; probe_x = 10'd0; probe_y = 10'd19;
        send_frame(YR, -1);
        // Frame D opens with new_frame coinciding with its first pixel.
        sq_en = 1'b1; probe_x = 10'd16; probe_y = 10'd10;
        send_line(XR, 0, 1'b1);
        check_results("frame C", XR, YR, 0, 0, 9'o750, 1);
        for (int y = 1; y < YR; y++) send_line(XR, y, 1'b0);
        pulse_nf("frame D", 1'b1);
        check_results("frame D", XR, YR, 0, 49, 9'o750, 1);

        pulse_nf("empty frame", 1'b1);
        check_results("empty frame", 0, 0, 1, 0, 0, 0);

        sq_en = 1'b0; match_rgb = 9'o750; probe_x = 10'd500; probe_y = 10'd0;
        send_frame(YR + 1, -1);
        pulse_nf("tall frame", 1'b1);
        check_results("tall frame", XR, YR + 1, 1, XR*(YR + 1), 0, 0);

        // Reset mid-frame: partial frame and the frame after release are never reported.
        send_frame(5, -1);
        rstb = 1'b0;
        repeat (2) tick();
        check("midreset frame_done", 32'(frame_done), 0);
        check_results("midreset", 0, 0, 0, 0, 0, 0);
        rstb = 1'b1;
        fd_base = fd_count;
        send_frame(5, -1);
        pulse_nf("post-reset first", 1'b0);
        sq_en = 1'b1; match_rgb = 9'o007; probe_x = 10'd16; probe_y = 10'd10;
        send_frame(YR, -1);
        check("post-reset no early frame_done", 32'(fd_count), 32'(fd_base));
        pulse_nf("post-reset second", 1'b1);
        check_results("post-reset", XR, YR, 0, 49, 9'o750, 1);

        // Nonzero data during blanking.
        tft.tft_red = 8'h01;
        tick();
        tft.tft_red = 8'h00;
        tick();
`ifdef TFT_MON_BLANK_CHECK_EN
        check("blank_err set", 32'(blank_err), 1);
        send_line(XR, 0, 1'b0);
        check("blank_err sticky", 32'(blank_err), 1);
`else
        check("blank_err tied", 32'(blank_err), 0);
        send_line(XR, 0, 1'b0);
        check("blank_err still tied", 32'(blank_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
